// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes / InvSubBytes: LANES shared S-box lanes walk the
// 128-bit state over 16/LANES beats, with valid/ready on both sides.

// Forward AES S-box lookup (FIPS-197), shared by the round datapath.
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Entry 0 sits in the most significant byte, so the table reads row by row.
    localparam logic [2047:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = FWD_TABLE[{~in_byte, 3'b000} +: 8];
endmodule

module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_inv
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GW    = 8 * LANES;

    if (LANES < 1 || LANES > 16 || (16 % LANES) != 0) begin : g_lanes_check
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   beat;
    logic            last_beat;
    logic            accept;
    logic            mode;
    logic [127:0]    work, work_nx;
    logic [GW-1:0]   grp_in, grp_out;

    assign last_beat = (beat == CW'(BEATS - 1));
    assign accept    = in_valid & in_ready;

    // Pick the byte group addressed by the beat counter.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        grp_in = '0;
        for (int g = 0; g < BEATS; g++) begin
            if (beat == CW'(g)) grp_in = work[g*GW +: GW];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] lane_in, lane_fwd, lane_inv;
        assign lane_in = grp_in[8*l +: 8];
        sbox u_sbox (.in_byte(lane_in), .out_byte(lane_fwd));
        assign lane_inv = INV_TABLE[{~lane_in, 3'b000} +: 8];
        assign grp_out[8*l +: 8] = mode ? lane_inv : lane_fwd;
    end

    // Substituted bytes overwrite the working copy in place.
    always_comb begin
        work_nx = work;
        for (int g = 0; g < BEATS; g++) begin
            if (beat == CW'(g)) work_nx[g*GW +: GW] = grp_out;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = BUSY;
            BUSY: if (last_beat) state_nx = DONE;
            DONE: if (out_ready) state_nx = in_valid ? BUSY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic; DONE accepts a new block in the same edge it hands one off.
    always_comb begin
        out_valid = (state == DONE);
        in_ready  = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE:    in_ready = 1'b1;
                DONE:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= '0;
            out_data <= '0;
            out_inv  <= 1'b0;
        end else begin
            if (accept)              beat <= '0;
            else if (state == BUSY)  beat <= last_beat ? '0 : beat + CW'(1);
            if (state == BUSY && last_beat) begin
                out_data <= work_nx;
                out_inv  <= mode;
            end
        end
    end

    // NOTE: the working copy and mode are pure datapath; they are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            work <= in_data;
            mode <= in_inv;
        end else if (state == BUSY) begin
            work <= work_nx;
        end
    end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter at LANES = 4, 1 and 16 with hand-derived
// FIPS-197 S-box vectors, backpressure, back-to-back and mid-block reset.
module tb_sub_bytes_iter;
    localparam logic [127:0] ZERO   = '0;
    localparam logic [127:0] ALL63  = {16{8'h63}};
    localparam logic [127:0] ALL52  = {16{8'h52}};
    localparam logic [127:0] ALL53  = {16{8'h53}};
    localparam logic [127:0] ALLED  = {16{8'hed}};
    localparam logic [127:0] ALL11  = {16{8'h11}};
    localparam logic [127:0] SEQ    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] SEQ_S  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] SEQ53  = 128'h0f0e0d0c0b0a09080706050453020100;
    localparam logic [127:0] SEQ53S = 128'h76abd7fe2b670130c56f6bf2ed777c63;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_inv = 1'b0;
    logic [127:0] in_data = '0;
    logic [2:0]   in_valid = '0;
    logic [2:0]   out_ready = '0;
    logic [2:0]   in_ready_w, out_valid_w, out_inv_w;
    logic [127:0] out_data_w [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_bytes_iter #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid_w[0]),
        .out_ready(out_ready[0]), .out_data(out_data_w[0]), .out_inv(out_inv_w[0])
    );
    sub_bytes_iter #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid_w[1]),
        .out_ready(out_ready[1]), .out_data(out_data_w[1]), .out_inv(out_inv_w[1])
    );
    sub_bytes_iter #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid_w[2]),
        .out_ready(out_ready[2]), .out_data(out_data_w[2]), .out_inv(out_inv_w[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge back in IDLE.
    task automatic run_block(input int idx, input logic [127:0] data, input logic inv,
                             input logic [127:0] exp, input int beats, input string tag);
        int n;
        in_data = data;
        in_inv = inv;
        in_valid[idx] = 1'b1;
        out_ready[idx] = 1'b0;
        check({tag, "_in_ready"}, 128'(in_ready_w[idx]), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        in_data = ALL11;
        n = 0;
        while (!out_valid_w[idx] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(beats));
        check({tag, "_data"}, out_data_w[idx], exp);
        check({tag, "_inv"}, 128'(out_inv_w[idx]), 128'(inv));
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        check({tag, "_drop"}, 128'(out_valid_w[idx]), 128'(0));
    endtask

    initial begin
        logic [127:0] blk [3];
        logic [127:0] blk_exp [3];
        int out_cyc [3];
        int k, r, n;
        logic acc;

        // Reset state across all three widths.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_valid_w), 128'(0));
        check("rst_in_ready", 128'(in_ready_w), 128'(0));
        check("rst_out_inv", 128'(out_inv_w), 128'(0));
        check("rst_out_data", out_data_w[0] | out_data_w[1] | out_data_w[2], ZERO);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready_w), 128'(3'b111));

        // LANES=4 forward / inverse vectors.
        run_block(0, ZERO,   1'b0, ALL63,  4, "l4_zero");
        run_block(0, SEQ,    1'b0, SEQ_S,  4, "l4_seq_fwd");
        run_block(0, SEQ_S,  1'b1, SEQ,    4, "l4_seq_inv");
        run_block(0, SEQ53,  1'b0, SEQ53S, 4, "l4_53_fwd");
        run_block(0, SEQ53S, 1'b1, SEQ53,  4, "l4_53_inv");
        run_block(0, ZERO,   1'b1, ALL52,  4, "l4_zero_inv");

        // Backpressure: DONE holds, nothing new is accepted.
        in_data = SEQ;
        in_inv = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid_w[0] && n < 64) begin
            @(negedge clk);
            n++;
        end
        in_data = ALL11;
        in_valid[0] = 1'b1;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_data_w[0] !== SEQ_S || in_ready_w[0] !== 1'b0 || out_valid_w[0] !== 1'b1) k++;
        end
        check("bp_hold_violations", 128'(k), 128'(0));
        check("bp_data", out_data_w[0], SEQ_S);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_no_accept_valid", 128'(out_valid_w[0]), 128'(0));
        check("bp_idle_ready", 128'(in_ready_w[0]), 128'(1));

        // Back-to-back with out_ready held high: one block per 5 cycles.
        blk[0] = ZERO;  blk_exp[0] = ALL63;
        blk[1] = SEQ;   blk_exp[1] = SEQ_S;
        blk[2] = ALL53; blk_exp[2] = ALLED;
        in_inv = 1'b0;
        in_data = blk[0];
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        k = 0;
        r = 0;
        acc = in_valid[0] & in_ready_w[0];
        for (int c = 0; c < 60 && r < 3; c++) begin
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 3) in_data = blk[k];
                else       in_valid[0] = 1'b0;
            end
            acc = in_valid[0] & in_ready_w[0];
            if (out_valid_w[0]) begin
                check($sformatf("b2b_data%0d", r), out_data_w[0], blk_exp[r]);
                out_cyc[r] = c;
                r++;
            end
        end
        check("b2b_count", 128'(r), 128'(3));
        if (r == 3) begin
            check("b2b_gap01", 128'(out_cyc[1] - out_cyc[0]), 128'(5));
            check("b2b_gap12", 128'(out_cyc[2] - out_cyc[1]), 128'(5));
        end
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("b2b_idle", 128'(in_ready_w[0]), 128'(1));

        // Reset in the middle of a block (beat 2).
        in_data = SEQ;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 128'(in_ready_w[1]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid_w[0]) k++;
        end
        check("mid_rst_no_valid", 128'(k), 128'(0));
        check("mid_rst_data", out_data_w[0], ZERO);
        run_block(0, ZERO, 1'b0, ALL63, 4, "mid_rst_next");

        // LANES=1 and LANES=16.
        run_block(1, ZERO,  1'b0, ALL63, 16, "l1_zero");
        run_block(1, SEQ,   1'b0, SEQ_S, 16, "l1_seq_fwd");
        run_block(1, SEQ_S, 1'b1, SEQ,   16, "l1_seq_inv");
        run_block(1, ALLED, 1'b1, ALL53, 16, "l1_ed_inv");
        run_block(2, ZERO,  1'b0, ALL63, 1,  "l16_zero");
        run_block(2, SEQ,   1'b0, SEQ_S, 1,  "l16_seq_fwd");
        run_block(2, SEQ_S, 1'b1, SEQ,   1,  "l16_seq_inv");
        run_block(2, SEQ53, 1'b0, SEQ53S, 1, "l16_53_fwd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
